// File: rtl/debounce_timer_if.sv
// rtl/debounce_timer_if.sv - request/response bundle between debounce FSM and its timer
interface debounce_timer_if #(
   parameter int CW = 4
);
   logic          SET;
   logic          CUENTAENA;
   logic          CUENTADONE;
   logic          TICK;
   logic [CW-1:0] COUNT;
   logic          BUSY;

   modport master (
      output SET,
      output CUENTAENA,
      input  CUENTADONE,
      input  TICK,
      input  COUNT,
      input  BUSY
   );

   modport slave (
      input  SET,
      input  CUENTAENA,
      output CUENTADONE,
      output TICK,
      output COUNT,
      output BUSY
   );
endinterface

// File: rtl/debounce_timer.sv
// rtl/debounce_timer.sv - prescaled tick counter answering debounce FSM SET/CUENTAENA requests
module debounce_timer #(
   parameter int PRESCALE = 100000,
   parameter int TICKS    = 10
) (
   input  logic             CLK,
   input  logic             RESET,
   debounce_timer_if.slave  bus
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int CW = ($clog2(TICKS + 1) > 1) ? $clog2(TICKS + 1) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] COUNT_LAST = CW'(TICKS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [CW-1:0] count_q, count_d;
   logic          tick_q, tick_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic          advance;

   // State and counter registers; RESET clears everything without waiting for a clock
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         count_q <= '0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         count_q <= count_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // Next state: SET clears, an enabled edge in IDLE or RUN advances the prescaler/tick cascade
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      count_d = count_q;
      tick_d  = 1'b0;
      advance = 1'b0;

      if (bus.SET) begin
         state_d = ST_IDLE;
         presc_d = '0;
         count_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // The edge that starts the run is itself the first counted edge
               if (bus.CUENTAENA) begin
                  state_d = ST_RUN;
                  advance = 1'b1;
               end
            end
            ST_RUN: begin
               // CUENTAENA low pauses with prescaler and count frozen
               if (bus.CUENTAENA) begin
                  advance = 1'b1;
               end
            end
            ST_DONE: begin
               // Terminal until SET or RESET; enable is ignored here
            end
            default: begin
               state_d = ST_IDLE;
               presc_d = '0;
               count_d = '0;
            end
         endcase
      end

      if (advance) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            count_d = count_q + CW'(1);
            if (count_q == COUNT_LAST) begin
               state_d = ST_DONE;
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end

      done_d = (state_d == ST_DONE);
      busy_d = (state_d == ST_RUN);
   end

   assign bus.CUENTADONE = done_q;
   assign bus.TICK       = tick_q;
   assign bus.COUNT      = count_q;
   assign bus.BUSY       = busy_q;
endmodule

// File: tb/tb_debounce_timer.sv
// tb/tb_debounce_timer.sv - scoreboard bench for debounce_timer across three parameter sets
module tb_debounce_timer;
   typedef struct {
      int done;
      int tick;
      int count;
      int busy;
   } exp_t;

   logic CLK;
   logic RESET;

   debounce_timer_if #(.CW(2)) i0 ();
   debounce_timer_if #(.CW(1)) i1 ();
   debounce_timer_if #(.CW(3)) i2 ();

   debounce_timer #(.PRESCALE(4), .TICKS(3)) dut0 (.CLK(CLK), .RESET(RESET), .bus(i0.slave));
   debounce_timer #(.PRESCALE(1), .TICKS(1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(i1.slave));
   debounce_timer #(.PRESCALE(1), .TICKS(5)) dut2 (.CLK(CLK), .RESET(RESET), .bus(i2.slave));

   int   pre_v[3] = '{4, 1, 1};
   int   tck_v[3] = '{3, 1, 5};
   int   ecnt[3];
   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int   n_cmp = 0;
   int   n_bad = 0;
   bit   armed = 0;
   event async_ev;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: an interval is simply a count of enabled edges since the last clear
   function automatic exp_t view(input int idx, input int tick);
      exp_t r;
      int   full;
      full    = pre_v[idx] * tck_v[idx];
      r.done  = (ecnt[idx] == full) ? 1 : 0;
      r.tick  = tick;
      r.count = ecnt[idx] / pre_v[idx];
      r.busy  = (ecnt[idx] > 0 && ecnt[idx] < full) ? 1 : 0;
      return r;
   endfunction

   function automatic exp_t model_edge(input int idx, input bit s, input bit en);
      int tick;
      tick = 0;
      if (s) begin
         ecnt[idx] = 0;
      end else if (en && ecnt[idx] < pre_v[idx] * tck_v[idx]) begin
         ecnt[idx]++;
         tick = (ecnt[idx] % pre_v[idx] == 0) ? 1 : 0;
      end
      return view(idx, tick);
   endfunction

   task automatic push_exp(input int idx, input exp_t e);
      case (idx)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic push_reset();
      for (int i = 0; i < 3; i++) begin
         ecnt[i] = 0;
         push_exp(i, view(i, 0));
      end
   endtask

   // One clock cycle of stimulus; optional asynchronous RESET pulse between edges afterwards
   task automatic step(input bit s, input bit en, input bit arst);
      #1;
      i0.SET = s; i0.CUENTAENA = en;
      i1.SET = s; i1.CUENTAENA = en;
      i2.SET = s; i2.CUENTAENA = en;
      @(posedge CLK);
      for (int i = 0; i < 3; i++) push_exp(i, model_edge(i, s, en));
      if (arst) begin
         #7;
         RESET = 1'b1;
         #1;
         push_reset();
         -> async_ev;
         @(posedge CLK);
         push_reset();
         #1;
         RESET = 1'b0;
      end
   endtask

   task automatic check_dut(input int idx, input int d, input int t, input int c, input int b);
      exp_t e;
      int   sz;
      case (idx)
         0: sz = q0.size();
         1: sz = q1.size();
         default: sz = q2.size();
      endcase
      if (sz == 0) begin
         chk($sformatf("dut%0d expectation available", idx), 0, 1);
      end else begin
         case (idx)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
         endcase
         chk($sformatf("dut%0d CUENTADONE", idx), d, e.done);
         chk($sformatf("dut%0d TICK", idx), t, e.tick);
         chk($sformatf("dut%0d COUNT", idx), c, e.count);
         chk($sformatf("dut%0d BUSY", idx), b, e.busy);
      end
   endtask

   // Monitor: each falling edge (or async-reset probe) consumes one expectation per DUT
   initial begin
      forever begin
         @(negedge CLK or async_ev);
         if (armed) begin
            check_dut(0, int'(i0.CUENTADONE), int'(i0.TICK), int'(i0.COUNT), int'(i0.BUSY));
            check_dut(1, int'(i1.CUENTADONE), int'(i1.TICK), int'(i1.COUNT), int'(i1.BUSY));
            check_dut(2, int'(i2.CUENTADONE), int'(i2.TICK), int'(i2.COUNT), int'(i2.BUSY));
         end
      end
   end

   initial begin
      RESET = 1'b1;
      i0.SET = 1'b0; i0.CUENTAENA = 1'b0;
      i1.SET = 1'b0; i1.CUENTAENA = 1'b0;
      i2.SET = 1'b0; i2.CUENTAENA = 1'b0;
      @(posedge CLK);
      push_reset();
      armed = 1'b1;
      #1;
      RESET = 1'b0;

      // Continuous enable through completion and a long hold in DONE
      repeat (32) step(1'b0, 1'b1, 1'b0);

      // Pause mid-interval then resume
      step(1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b1, 1'b0);
      repeat (7) step(1'b0, 1'b0, 1'b0);
      repeat (10) step(1'b0, 1'b1, 1'b0);

      // SET out of DONE, then a fresh run
      step(1'b1, 1'b1, 1'b0);
      repeat (14) step(1'b0, 1'b1, 1'b0);

      // SET and CUENTAENA together: SET wins
      repeat (3) step(1'b1, 1'b1, 1'b0);
      repeat (14) step(1'b0, 1'b1, 1'b0);

      // Asynchronous reset with COUNT=2 on the 4/3 instance
      step(1'b1, 1'b0, 1'b0);
      repeat (8) step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      repeat (14) step(1'b0, 1'b1, 1'b0);

      // Randomised traffic with occasional SET and asynchronous reset
      for (int k = 0; k < 500; k++) begin
         step(($urandom % 25) == 0, ($urandom % 6) != 0, ($urandom % 120) == 0);
      end

      #1;
      i0.SET = 1'b0; i1.SET = 1'b0; i2.SET = 1'b0;
      @(negedge CLK);
      #1;
      chk("scoreboard drained", q0.size() + q1.size() + q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end
endmodule
